// File: rtl/ll_cmd_frontend.sv
// rtl/ll_cmd_frontend.sv - switch synchroniser, debouncer, op-change detector and command FIFO
module ll_cmd_frontend #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_WIDTH       = 20,
    parameter int FIFO_DEPTH      = 4,
    parameter int FIFO_AW         = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        sw_raw,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [2:0]         cmd_op,
    output logic [7:0]         cmd_data,
    output logic               cmd_dropped,
    output logic [FIFO_AW:0]   fifo_level
);

    typedef enum logic {S_STABLE, S_COUNT} state_t;

    state_t                 state, state_next;
    logic [15:0]            sw_meta, sw_sync;
    logic [15:0]            sw_cand, cand_next;
    logic [15:0]            sw_stable, stable_next;
    logic [CNT_WIDTH-1:0]   cnt, cnt_next;
    logic [2:0]             prev_op;
    logic                   evt;

    logic [10:0]            mem [FIFO_DEPTH];
    logic [FIFO_AW:0]       wr_ptr, rd_ptr;
    logic                   empty, full, push, pop;
    logic [10:0]            head;

    // two-flop synchroniser for the asynchronous switches
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_raw;
            sw_sync <= sw_meta;
        end
    end

    // debounce state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_STABLE;
            cnt       <= '0;
            sw_cand   <= '0;
            sw_stable <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            sw_cand   <= cand_next;
            sw_stable <= stable_next;
        end
    end

    // debounce next state: any change in the synchronised value restarts the count
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        cand_next   = sw_cand;
        stable_next = sw_stable;
        if (sw_sync != sw_cand) begin
            cand_next  = sw_sync;
            cnt_next   = '0;
            state_next = S_COUNT;
        end else if (state == S_COUNT) begin
            if (sw_cand == sw_stable) begin
                cnt_next   = '0;
                state_next = S_STABLE;
            end else if (cnt == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
                stable_next = sw_cand;
                cnt_next    = '0;
                state_next  = S_STABLE;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    // remember the committed op so a change is visible for exactly one cycle
    always_ff @(posedge clk) begin
        if (rst) prev_op <= '0;
        else     prev_op <= sw_stable[15:13];
    end

    assign evt = (sw_stable[15:13] != prev_op) && (sw_stable[15:13] != 3'b000);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop   = cmd_valid && cmd_ready;
    assign push  = evt && (!full || pop);

    // command storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {sw_stable[15:13], sw_stable[7:0]};
    end

    // FIFO pointers and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cmd_dropped <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (evt && full && !pop) cmd_dropped <= 1'b1;
        end
    end

    assign head       = mem[rd_ptr[FIFO_AW-1:0]];
    assign cmd_valid  = !empty;
    assign cmd_op     = cmd_valid ? head[10:8] : 3'b000;
    assign cmd_data   = cmd_valid ? head[7:0]  : 8'h00;
    assign fifo_level = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_ll_cmd_frontend.sv
// tb/tb_ll_cmd_frontend.sv - randomized and directed bench for ll_cmd_frontend against a queue model
module tb_ll_cmd_frontend;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw_raw;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic        cmd_dropped;
    logic [2:0]  fifo_level;

    int total = 0;
    int bad   = 0;
    int valid_cycles = 0;

    ll_cmd_frontend #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_WIDTH(20),
        .FIFO_DEPTH(4),
        .FIFO_AW(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_raw(sw_raw),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_data(cmd_data),
        .cmd_dropped(cmd_dropped),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // reference model: a switch value is committed once its synchronised copy has
    // been seen DEB+1 times in a row; an op change to non-zero queues a command
    logic [15:0] m_s1 = '0, m_s2 = '0, m_last = '0, m_stable = '0;
    int          m_run = DEB + 2;
    bit          m_evt = 1'b0;
    logic [10:0] m_evt_cmd = '0;
    logic [10:0] m_q[$];
    bit          m_drop = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_last = '0; m_stable = '0;
            m_run = DEB + 2; m_evt = 1'b0; m_drop = 1'b0;
            m_q.delete();
        end else begin
            if (m_q.size() > 0 && cmd_ready) void'(m_q.pop_front());
            if (m_evt) begin
                if (m_q.size() < 4) m_q.push_back(m_evt_cmd);
                else                m_drop = 1'b1;
            end
            m_evt = 1'b0;
            if (m_s2 == m_last) begin
                if (m_run < DEB + 2) m_run++;
            end else begin
                m_last = m_s2;
                m_run  = 1;
            end
            if (m_run == DEB + 1 && m_last != m_stable) begin
                if (m_last[15:13] != m_stable[15:13] && m_last[15:13] != 3'b000) begin
                    m_evt     = 1'b1;
                    m_evt_cmd = {m_last[15:13], m_last[7:0]};
                end
                m_stable = m_last;
            end
            m_s2 = m_s1;
            m_s1 = sw_raw;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance one cycle and compare every output against the model
    task automatic step();
        logic [10:0] h;
        @(negedge clk);
        h = (m_q.size() > 0) ? m_q[0] : 11'h000;
        check("valid", 32'(cmd_valid), 32'(m_q.size() > 0));
        check("op",    32'(cmd_op),    32'(h[10:8]));
        check("data",  32'(cmd_data),  32'(h[7:0]));
        check("level", 32'(fifo_level), 32'(m_q.size()));
        check("drop",  32'(cmd_dropped), 32'(m_drop));
        if (cmd_valid) valid_cycles++;
    endtask

    task automatic hold(input logic [15:0] v, input int n, input logic rdy);
        sw_raw    = v;
        cmd_ready = rdy;
        repeat (n) step();
    endtask

    initial begin
        rst = 1'b1; sw_raw = 16'h0000; cmd_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);

        // basic command: one valid cycle, op 101 data 3C
        hold(16'h0000, 6, 1'b1);
        valid_cycles = 0;
        hold(16'hA03C, 7, 1'b1);
        check("t1_early", 32'(cmd_valid), 32'd0);
        step();
        check("t1_valid", 32'(cmd_valid), 32'd1);
        check("t1_op",    32'(cmd_op),    32'd5);
        check("t1_data",  32'(cmd_data),  32'h3C);
        hold(16'hA03C, 12, 1'b1);
        check("t1_pulses", 32'(valid_cycles), 32'd1);

        // bounce rejection
        hold(16'h0000, 10, 1'b1);
        for (int i = 0; i < 5; i++) begin
            hold(16'h0055, 2, 1'b1);
            hold(16'h8055, 2, 1'b1);
        end
        hold(16'h8055, 15, 1'b1);

        // backpressure and hold
        hold(16'h0000, 10, 1'b0);
        hold(16'h8001, 10, 1'b0);
        hold(16'h0000, 10, 1'b0);
        hold(16'hC002, 10, 1'b0);
        hold(16'h0000, 10, 1'b0);
        hold(16'hE003, 10, 1'b0);
        check("t3_level", 32'(fifo_level), 32'd3);
        check("t3_op",    32'(cmd_op),    32'd4);
        check("t3_data",  32'(cmd_data),  32'h01);
        hold(16'hE003, 5, 1'b1);

        // overflow, then push while popping at full
        hold(16'h0000, 10, 1'b0);
        hold(16'h2001, 10, 1'b0); hold(16'h0000, 10, 1'b0);
        hold(16'h4002, 10, 1'b0); hold(16'h0000, 10, 1'b0);
        hold(16'h6003, 10, 1'b0); hold(16'h0000, 10, 1'b0);
        hold(16'h8004, 10, 1'b0); hold(16'h0000, 10, 1'b0);
        hold(16'hA005, 10, 1'b0);
        check("t4_level", 32'(fifo_level), 32'd4);
        check("t4_drop",  32'(cmd_dropped), 32'd1);
        hold(16'h0000, 10, 1'b0);
        hold(16'hC006, 7, 1'b0);
        hold(16'hC006, 1, 1'b1);
        hold(16'hC006, 3, 1'b0);
        check("t4_full_again", 32'(fifo_level), 32'd4);
        hold(16'hC006, 8, 1'b1);

        // no-trigger cases
        hold(16'hA011, 10, 1'b1);
        hold(16'hA022, 10, 1'b1);
        hold(16'h0022, 10, 1'b1);
        hold(16'hA022, 10, 1'b1);

        // reset mid-handshake with switches already set
        hold(16'h0000, 10, 1'b0);
        hold(16'h2001, 10, 1'b0); hold(16'h0000, 10, 1'b0);
        hold(16'h4002, 10, 1'b0);
        check("t6_pre_level", 32'(fifo_level), 32'd2);
        sw_raw = 16'hE0FF;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_valid", 32'(cmd_valid), 32'd0);
        check("t6_level", 32'(fifo_level), 32'd0);
        check("t6_drop",  32'(cmd_dropped), 32'd0);
        hold(16'hE0FF, 12, 1'b0);
        check("t6_cmd_level", 32'(fifo_level), 32'd1);
        check("t6_cmd_op",    32'(cmd_op),    32'd7);
        check("t6_cmd_data",  32'(cmd_data),  32'hFF);
        hold(16'hE0FF, 3, 1'b1);

        // randomized: bouncy switch settings, random backpressure, rare resets
        for (int k = 0; k < 400; k++) begin
            logic [15:0] v;
            int          n;
            v = {3'($urandom_range(0, 7)), 5'($urandom), 8'($urandom_range(0, 3))};
            n = $urandom_range(1, 14);
            sw_raw = v;
            for (int c = 0; c < n; c++) begin
                cmd_ready = ($urandom_range(0, 9) < 4);
                rst = ($urandom_range(0, 299) == 0);
                step();
            end
            rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ll_cmd_frontend.md
Name: ll_cmd_frontend

Overview:
- Front-end stage between the board switches and the linked-list controller.
- Synchronises and debounces the 16 raw switches and detects a new non-idle operation code.
- Turns each detected operation into exactly one command {op, data} in a small FIFO.
- Presents commands to the downstream controller over a valid/ready handshake, so one switch setting yields exactly one operation, even while the controller is busy traversing or searching.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: cycles `sw_sync` must stay constant before it is committed (10 ms at 100 MHz).
- CNT_WIDTH, 20: debounce counter width; must hold DEBOUNCE_CYCLES-1.
- FIFO_DEPTH, 4: command FIFO entries; power of two.
- FIFO_AW, 2: log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- sw_raw  in  16  asynchronous switch inputs; [15:13] = op, [7:0] = data, [12:8] ignored.
- cmd_valid  out  1  FIFO head holds a command.
- cmd_ready  in  1  downstream accepts the head this cycle.
- cmd_op  out  3  head op code; 3'b000 when empty.
- cmd_data  out  8  head data; 8'h00 when empty.
- cmd_dropped  out  1  sticky: a command was lost because the FIFO was full.
- fifo_level  out  FIFO_AW+1  entries currently held, 0..FIFO_DEPTH.

Behaviour:
- **Reset values:** all outputs 0. `sw_sync`, `sw_cand` and `sw_stable` are 0, counter 0, FIFO empty, debounce FSM in S_STABLE.
- **Synchroniser:** two flops, sw_raw -> sw_meta -> sw_sync.
- **Candidate tracking (every cycle):** if sw_sync != sw_cand then sw_cand <= sw_sync, cnt <= 0, FSM -> S_COUNT. This restarts the count on any bounce.
- **Debounce FSM, S_STABLE:** no counting.
- **Debounce FSM, S_COUNT:** if sw_cand == sw_stable then go to S_STABLE with cnt 0. Else if cnt == DEBOUNCE_CYCLES-1 then sw_stable <= sw_cand (all 16 bits in one cycle), cnt <= 0, go to S_STABLE. Else cnt++.
- **Commit latency:** a clean switch change reaches sw_stable 2 + 1 + DEBOUNCE_CYCLES cycles after sw_raw changes.
- **Event detection:** event fires in the cycle after the commit when new_op != old_op and new_op != 3'b000. Here new_op = sw_stable[15:13] after the commit and old_op = the value before it.
  - Event payload is {new_op, sw_stable[7:0]} from the same commit.
  - A data-only change never fires an event.
  - A return to op 000 fires no event.
  - Going op A -> 000 -> A fires two events.
- **FIFO:** first-word-fall-through, registered storage, read/write pointers FIFO_AW+1 bits wide.
  - Push on event when not full.
  - Pop when cmd_valid && cmd_ready.
  - Simultaneous push and pop while full: both happen, level unchanged, no drop.
  - Simultaneous push and pop while empty is impossible (cmd_valid is 0), so the push alone occurs.
  - Event while full with no pop: entry discarded, cmd_dropped <= 1. cmd_dropped stays 1 until rst.
- **Output timing:** cmd_valid rises the cycle after a push into an empty FIFO.
  - cmd_op/cmd_data stay stable while cmd_valid && !cmd_ready.
  - Next entry appears the cycle after a pop.
  - fifo_level updates the cycle after each push or pop.
- **Reset behaviour:**
  - rst mid-handshake or mid-debounce: FIFO flushed, cmd_valid 0 the cycle after rst is sampled, no partial command.
  - Because sw_stable resets to 0, switches already set to a non-zero op at reset produce one command after the debounce time.
- **Pointer wrap:** wrap-around is natural modulo 2^(FIFO_AW+1). Full = MSBs differ and low bits equal.

Test Plan:
- **T1, basic command (DEBOUNCE_CYCLES=4 for all tests):** sw_raw 16'h0000 -> 16'hA03C held, cmd_ready=1 -> exactly one cycle with cmd_valid=1, cmd_op=3'b101, cmd_data=8'h3C, 8 cycles after the change; fifo_level returns to 0.
- **T2, bounce rejection:** toggle sw_raw[15:13] between 000 and 100 every 2 cycles for 20 cycles, then hold 100 with data 8'h55 -> one command (100, 55), issued only after 4 stable cycles; no command during toggling.
- **T3, backpressure and hold:** cmd_ready=0; issue ops 100/01, 000, 110/02, 000, 111/03 -> fifo_level=3; cmd_op/cmd_data stay 100/01 throughout; raising cmd_ready pops 100/01, 110/02, 111/03 in order on consecutive cycles.
- **T4, overflow:** cmd_ready=0; push 5 distinct commands -> fifo_level=4, cmd_dropped=1, 5th command absent. Then push while popping at full -> level stays 4, accepted, no extra drop.
- **T5, no-trigger cases:** op held at 101 while data changes 8'h11 -> 8'h22 -> no command; op 101 -> 000 -> no command; op 000 -> 101 -> one command with data 8'h22.
- **T6, reset:** assert rst for 1 cycle while fifo_level=2 and cmd_valid=1 -> next cycle cmd_valid=0, fifo_level=0, cmd_dropped=0; with switches at 16'hE0FF, one command (111, FF) follows the debounce time.
